// File: rtl/instr_decode_pipe.sv
// Issue/decode stage for the regfile + alupipe datapath.
// One-hot read/write selects, ALU controls, RAW stall (no forwarding).
module instr_decode_pipe #(
  parameter int DSEL_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ibus,
  input  logic             ivalid,
  output logic             iready,
  output logic [31:0]      Aselect,
  output logic [31:0]      Bselect,
  output logic [31:0]      Dselect,
  output logic [2:0]       S,
  output logic             Cin,
  output logic             illegal_op,
  output logic [CNT_W-1:0] issue_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] s;
    logic       cin;
  } id_t;

  localparam id_t BUBBLE = '0;

  id_t        id_q;
  id_t        id_d;
  logic [DSEL_LAT:1] dq_v;
  logic [4:0] dq_rd [1:DSEL_LAT];

  logic [5:0] op;
  logic [4:0] in_rs;
  logic [4:0] in_rt;
  logic [4:0] in_rd;
  logic       legal;
  logic       rs_hit;
  logic       rt_hit;
  logic       hazard;
  logic       accept;
  logic       unused_bits;

  assign op     = ibus[31:26];
  assign in_rs  = ibus[25:21];
  assign in_rt  = ibus[20:16];
  assign in_rd  = ibus[15:11];
  assign unused_bits = ^ibus[10:0];

  // s=111 and any nonzero high opcode bits have no ALU meaning
  assign legal = (op[5:3] == 3'b000) && (op[2:0] != 3'b111);

  // Compare sources against writers that retire after this word reads;
  // the last delay slot writes on the same edge, so it is safe.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    if (id_q.v && id_q.rd == in_rs) rs_hit = 1'b1;
    if (id_q.v && id_q.rd == in_rt) rt_hit = 1'b1;
    for (int i = 1; i < DSEL_LAT; i++) begin
      if (dq_v[i] && dq_rd[i] == in_rs) rs_hit = 1'b1;
      if (dq_v[i] && dq_rd[i] == in_rt) rt_hit = 1'b1;
    end
  end

  assign hazard = ivalid &
                  (((in_rs != 5'd0) & rs_hit) |
                   ((in_rt != 5'd0) & rt_hit));
  assign iready = ~hazard;
  assign accept = ivalid & iready;

  // Next ID entry: decoded word on legal accept, bubble otherwise
  always_comb begin
    id_d = BUBBLE;
    if (accept && legal) begin
      id_d.v   = 1'b1;
      id_d.rs  = in_rs;
      id_d.rt  = in_rt;
      id_d.rd  = in_rd;
      id_d.s   = op[2:0];
      id_d.cin = (op[2:0] == 3'b011);
    end
  end

  // Advance ID and the write-select delay line every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= BUBBLE;
      dq_v <= '0;
      for (int i = 1; i <= DSEL_LAT; i++) dq_rd[i] <= 5'd0;
    end else begin
      id_q     <= id_d;
      dq_v[1]  <= id_q.v;
      dq_rd[1] <= id_q.rd;
      for (int i = 2; i <= DSEL_LAT; i++) begin
        dq_v[i]  <= dq_v[i-1];
        dq_rd[i] <= dq_rd[i-1];
      end
    end
  end

  // Illegal-word pulse and issued-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op  <= 1'b0;
      issue_count <= '0;
    end else begin
      illegal_op <= accept & ~legal;
      if (accept && legal)
        issue_count <= issue_count + CNT_W'(1);
    end
  end

  assign Aselect = 32'h1 << id_q.rs;
  assign Bselect = 32'h1 << id_q.rt;
  assign S       = id_q.s;
  assign Cin     = id_q.cin;
  assign Dselect = dq_v[DSEL_LAT] ? (32'h1 << dq_rd[DSEL_LAT])
                                  : 32'h1;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe.
// Model tracks per-register write retirement time.
module tb_instr_decode_pipe;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ibus = '0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [31:0] Aselect;
  logic [31:0] Bselect;
  logic [31:0] Dselect;
  logic [2:0]  S;
  logic        Cin;
  logic        illegal_op;
  logic [15:0] issue_count;

  instr_decode_pipe #(.DSEL_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ibus(ibus), .ivalid(ivalid),
    .iready(iready), .Aselect(Aselect), .Bselect(Bselect),
    .Dselect(Dselect), .S(S), .Cin(Cin),
    .illegal_op(illegal_op), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  s;
    logic        cin;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] dsq[$];
  exp_t        mx;
  logic [31:0] md;

  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 0;
  int          e = 0;
  int          busy [32];
  logic [15:0] m_cnt = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int op, int rs, int rt, int rd);
    logic [31:0] w;
    logic [31:0] r;
    r = $urandom;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], r[10:0]};
    return w;
  endfunction

  function automatic bit model_haz(logic [31:0] w);
    int rs;
    int rt;
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    return (rs != 0 && busy[rs] >= e + 1) ||
           (rt != 0 && busy[rt] >= e + 1);
  endfunction

  // Monitor: one expected record and one Dselect per clock
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (eq.size() == 0 || dsq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got %0d/%0d entries expected >0",
                 eq.size(), dsq.size());
      end else begin
        mx = eq.pop_front();
        md = dsq.pop_front();
        chk("Aselect", Aselect, mx.a);
        chk("Bselect", Bselect, mx.b);
        chk("S", 32'(S), 32'(mx.s));
        chk("Cin", 32'(Cin), 32'(mx.cin));
        chk("illegal_op", 32'(illegal_op), 32'(mx.ill));
        chk("issue_count", 32'(issue_count), 32'(mx.cnt));
        chk("Dselect", Dselect, md);
      end
    end
  end

  // One clock of stimulus; model decides acceptance and pushes expectations
  task automatic cycle(input logic v, input logic [31:0] w, output bit acc);
    bit   rdy;
    bit   leg;
    exp_t x;
    int   op;
    ibus   = w;
    ivalid = v;
    #1;
    rdy = !(v && model_haz(w));
    chk("iready", 32'(iready), 32'(rdy));
    @(posedge clk);
    e++;
    acc = v && rdy;
    op  = int'(w[31:26]);
    leg = (op <= 6);
    x.a = 32'h1; x.b = 32'h1; x.s = 3'd0; x.cin = 1'b0;
    x.ill = acc && !leg;
    if (acc && leg) begin
      x.a   = 32'h1 << w[25:21];
      x.b   = 32'h1 << w[20:16];
      x.s   = w[28:26];
      x.cin = (op == 3);
      m_cnt = m_cnt + 16'd1;
      busy[int'(w[15:11])] = e + LAT;
    end
    x.cnt = m_cnt;
    eq.push_back(x);
    dsq.push_back((acc && leg) ? (32'h1 << w[15:11]) : 32'h1);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, output int tries);
    bit acc;
    tries = 0;
    acc = 0;
    while (!acc && tries < 8) begin
      cycle(1'b1, w, acc);
      tries++;
    end
    ivalid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, acc);
  endtask

  task automatic do_reset();
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_A", Aselect, 32'h1);
    chk("rst_B", Bselect, 32'h1);
    chk("rst_D", Dselect, 32'h1);
    chk("rst_S", 32'(S), 0);
    chk("rst_Cin", 32'(Cin), 0);
    chk("rst_ill", 32'(illegal_op), 0);
    chk("rst_cnt", 32'(issue_count), 0);
    chk("rst_iready", 32'(iready), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    eq.delete();
    dsq.delete();
    for (int i = 0; i < LAT; i++) dsq.push_back(32'h1);
    for (int i = 0; i < 32; i++) busy[i] = 0;
    e = 0;
    m_cnt = '0;
    #1;
    chk("post_rst_iready", 32'(iready), 1);
    ivalid = 1'b0;
    mon_en = 1;
  endtask

  initial begin
    int t;
    int op;
    bit acc;
    logic [31:0] w;
    logic [15:0] c0;
    for (int i = 0; i < 32; i++) busy[i] = 0;
    do_reset();

    // independent ADD then AND, no stall
    send(mk(2, 1, 2, 3), t);  chk("t2_first", t, 1);
    send(mk(6, 4, 5, 6), t);  chk("t2_second", t, 1);
    idle(3);

    // SUB r1,r2->r3 then XOR r3,r0->r7 stalls two clocks
    send(mk(3, 1, 2, 3), t);  chk("t3_sub", t, 1);
    send(mk(0, 3, 0, 7), t);  chk("t3_xor_tries", t, 3);
    idle(4);

    // write r0, then read r0: no stall
    send(mk(2, 1, 2, 0), t);  chk("t4_w0", t, 1);
    send(mk(0, 0, 0, 4), t);  chk("t4_r0", t, 1);
    idle(3);

    // two illegal opcodes
    c0 = m_cnt;
    send(mk(7, 1, 2, 3), t);   chk("t5_ill1", t, 1);
    send(mk(32, 1, 2, 3), t);  chk("t5_ill2", t, 1);
    idle(2);
    chk("t5_cnt", 32'(issue_count), 32'(c0));

    // randomized stream with hazards and idle gaps
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b0, $urandom, acc);
      end else begin
        op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                         : int'($urandom_range(0, 6));
        w = mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7));
        send(w, t);
      end
    end
    idle(3);

    // reset while rd=5 in flight and a dependent word is stalled
    send(mk(3, 1, 2, 5), t);
    cycle(1'b1, mk(0, 5, 0, 7), acc);
    chk("t1_stalled", 32'(acc), 0);
    chk("t1_iready_pre", 32'(iready), 0);
    do_reset();
    idle(5);

    // counter wrap: 65537 independent legal words
    for (int n = 0; n < 65537; n++) begin
      send(mk($urandom_range(0, 6), 0, 0, $urandom_range(0, 31)), t);
      if (t != 1) chk("wrap_stall", t, 1);
    end
    idle(3);
    chk("wrap_count", 32'(issue_count), 1);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
